// File: rtl/tone_pkg.sv
// Shared note indices, FSM state type and board-default timing constants
// for the three-button tone voice arbiter.
package tone_pkg;

  localparam logic [1:0] NOTE_CS   = 2'd0;
  localparam logic [1:0] NOTE_DS   = 2'd1;
  localparam logic [1:0] NOTE_FS   = 2'd2;
  localparam logic [1:0] NOTE_NONE = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  // Defaults assume the 27 MHz board clock.
  localparam int unsigned DEF_CW         = 21;
  localparam int unsigned DEF_PERIOD0    = 97122;
  localparam int unsigned DEF_PERIOD1    = 86816;
  localparam int unsigned DEF_PERIOD2    = 72974;
  localparam int unsigned DEF_DEB_CYCLES = 270000;

endpackage

// File: rtl/tone_voice_arbiter_btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for one push-button.
// press pulses in the cycle whose edge raises held from 0 to 1.
module btn_debounce
  import tone_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic held,
  output logic press
);

  localparam int unsigned CNTW = $clog2(DEB_CYCLES + 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            held_q, held_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    held_d  = held_q;
    cnt_d   = '0;
    // Any cycle where the synced level agrees with held restarts the count.
    if (sync2_q != held_q) begin
      if (cnt_q == CNTW'(DEB_CYCLES - 1)) begin
        held_d = ~held_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held  = held_q;
  assign press = held_d & ~held_q;

endmodule

// File: rtl/tone_voice_arbiter.sv
// Three debounced note buttons share one square-wave generator; the most
// recently pressed held button wins, and note changes wait for a period end.
module tone_voice_arbiter
  import tone_pkg::*;
#(
  parameter int unsigned CW         = DEF_CW,
  parameter int unsigned PERIOD0    = DEF_PERIOD0,
  parameter int unsigned PERIOD1    = DEF_PERIOD1,
  parameter int unsigned PERIOD2    = DEF_PERIOD2,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  output logic       tone_out,
  output logic       active,
  output logic [1:0] note_idx
);

  if (PERIOD0 < 2 || longint'(PERIOD0) >= (longint'(1) << CW)) begin : g_bad_p0
    $error("tone_voice_arbiter: PERIOD0 out of range");
  end
  if (PERIOD1 < 2 || longint'(PERIOD1) >= (longint'(1) << CW)) begin : g_bad_p1
    $error("tone_voice_arbiter: PERIOD1 out of range");
  end
  if (PERIOD2 < 2 || longint'(PERIOD2) >= (longint'(1) << CW)) begin : g_bad_p2
    $error("tone_voice_arbiter: PERIOD2 out of range");
  end
  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("tone_voice_arbiter: DEB_CYCLES must be at least 1");
  end

  logic [2:0] held;
  logic [2:0] press;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn[g]),
      .held   (held[g]),
      .press  (press[g])
    );
  end

  logic [1:0]    last_req_q, last_req_d;
  logic [1:0]    target;
  logic          target_valid;
  state_e        state_q, state_d;
  logic [1:0]    cur_q, cur_d;
  logic [CW-1:0] phase_q, phase_d;
  logic          tone_q, tone_d;
  logic [CW-1:0] cur_period;
  logic [CW-1:0] phase_next;

  // Descending scan so the lowest index wins when presses coincide.
  always_comb begin
    last_req_d = last_req_q;
    for (int i = 2; i >= 0; i--) begin
      if (press[i]) last_req_d = 2'(i);
    end
  end

  always_comb begin
    target       = NOTE_NONE;
    target_valid = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (held[i]) begin
        target       = 2'(i);
        target_valid = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (held[i] && last_req_q == 2'(i)) target = 2'(i);
    end
  end

  always_comb begin
    case (cur_q)
      NOTE_DS: cur_period = CW'(PERIOD1);
      NOTE_FS: cur_period = CW'(PERIOD2);
      default: cur_period = CW'(PERIOD0);
    endcase
  end

  assign phase_next = phase_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    phase_d = phase_q;
    tone_d  = tone_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        tone_d  = 1'b0;
        cur_d   = NOTE_NONE;
        if (target_valid) begin
          state_d = PLAY;
          cur_d   = target;
          tone_d  = 1'b1;
        end
      end
      PLAY: begin
        // The target is only consulted at the last cycle of a period.
        if (phase_q == cur_period - CW'(1)) begin
          phase_d = '0;
          if (target_valid) begin
            cur_d  = target;
            tone_d = 1'b1;
          end else begin
            state_d = IDLE;
            cur_d   = NOTE_NONE;
            tone_d  = 1'b0;
          end
        end else begin
          phase_d = phase_next;
          tone_d  = (phase_next < (cur_period >> 1));
        end
      end
      default: begin
        state_d = IDLE;
        cur_d   = NOTE_NONE;
        phase_d = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_q      <= NOTE_NONE;
      phase_q    <= '0;
      tone_q     <= 1'b0;
      last_req_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      phase_q    <= phase_d;
      tone_q     <= tone_d;
      last_req_q <= last_req_d;
    end
  end

  assign tone_out = tone_q;
  assign active   = (state_q == PLAY);
  assign note_idx = cur_q;

endmodule
